// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants, opcodes and FSM states for the ALU round-robin scheduler.
// Contents: DW (datapath width), OP_* opcode encodings, state_t (IDLE/EXEC/RESP).
package alu_sched_pkg;
    localparam int DW = 8;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_GT   = 3'd5;
    localparam logic [2:0] OP_SHLA = 3'd6;
    localparam logic [2:0] OP_SHLB = 3'd7;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_rr_sched_alu.sv
// alu8: 8-bit add/sub/logic ALU, purely combinational.
// Ports: a, b (operands), op (opcode) -> out (result), cout (carry/no-borrow), z (out == 0).
module alu8
    import alu_sched_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] out,
    output logic          cout,
    output logic          z
);
    logic [DW:0] sum;
    logic [DW:0] dif;
    assign sum = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: bit DW is set exactly when no borrow occurs (a >= b)
    assign dif = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
    always_comb begin
        out  = op == OP_ADD  ? sum[DW-1:0] :
               op == OP_SUB  ? dif[DW-1:0] :
               op == OP_AND  ? (a & b) :
               op == OP_OR   ? (a | b) :
               op == OP_XOR  ? (a ^ b) :
               op == OP_GT   ? DW'(a > b) :
               op == OP_SHLA ? {a[DW-2:0], 1'b0} :
                               {b[DW-2:0], 1'b0};
        cout = op == OP_ADD ? sum[DW] : op == OP_SUB ? dif[DW] : 1'b0;
        z    = out == '0;
    end
endmodule

// File: rtl/alu_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the pointer register lives in the parent.
// Ports: req (request vector), ptr (first index to consider) -> gnt (one-hot or zero), idx (winner index).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic [IDW-1:0] j;
    logic           hit;
    // Scan offsets from farthest to nearest so the nearest valid index at or after ptr wins.
    always_comb begin
        j   = '0;
        idx = '0;
        hit = 1'b0;
        gnt = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                idx = j;
                hit = 1'b1;
            end
        end
        gnt[idx] = hit;
    end
endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one 8-bit ALU between NREQ requesters.
// Ports: clk, rst (async active-high); req_valid/req_ready/req_a/req_b/req_op (packed per requester);
//        rsp_valid/rsp_ready/rsp_id/rsp_out/rsp_cout/rsp_z (shared response channel).
// Option ALU_RR_SCHED_STICKY_EN adds sticky_clr input and sticky_c/sticky_z sticky flag outputs.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW-1:0]     rsp_out,
    output logic              rsp_cout,
    output logic              rsp_z
`ifdef ALU_RR_SCHED_STICKY_EN
    ,
    input  logic              sticky_clr,
    output logic              sticky_c,
    output logic              sticky_z
`endif
);
    state_t          state_q;
    state_t          state_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [2:0]      op_q;
    logic [DW-1:0]   alu_out;
    logic            alu_cout;
    logic            alu_z;
    logic            grant;
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win)
    );
    alu8 u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .out  (alu_out),
        .cout (alu_cout),
        .z    (alu_z)
    );
    assign grant = state_q == IDLE && |gnt;
    always_comb begin
        req_ready = state_q == IDLE ? gnt : '0;
        state_d   = state_q == IDLE ? (grant ? EXEC : IDLE) :
                    state_q == EXEC ? RESP :
                    (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
            rsp_cout  <= 1'b0;
            rsp_z     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                a_q    <= req_a[int'(win)*8 +: 8];
                b_q    <= req_b[int'(win)*8 +: 8];
                op_q   <= req_op[int'(win)*3 +: 3];
                id_q   <= win;
                rr_ptr <= win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
            end
            if (state_q == EXEC) begin
                rsp_out   <= alu_out;
                rsp_cout  <= alu_cout;
                rsp_z     <= alu_z;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
`ifdef ALU_RR_SCHED_STICKY_EN
    // Set wins over clear when both happen on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_c <= 1'b0;
            sticky_z <= 1'b0;
        end else begin
            sticky_c <= (state_q == EXEC && alu_cout) || (sticky_c && !sticky_clr);
            sticky_z <= (state_q == EXEC && alu_z) || (sticky_z && !sticky_clr);
        end
    end
`endif
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: self-checking bench for alu_rr_sched (table vectors + scoreboard + corner sequences).
module tb_alu_rr_sched;
    import alu_sched_pkg::*;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a = '0;
    logic [NREQ*8-1:0] req_b = '0;
    logic [NREQ*3-1:0] req_op = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_out;
    logic              rsp_cout;
    logic              rsp_z;
`ifdef ALU_RR_SCHED_STICKY_EN
    logic              sticky_clr = 1'b0;
    logic              sticky_c;
    logic              sticky_z;
`endif
    alu_rr_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_cout  (rsp_cout),
        .rsp_z     (rsp_z)
`ifdef ALU_RR_SCHED_STICKY_EN
        ,
        .sticky_clr(sticky_clr),
        .sticky_c  (sticky_c),
        .sticky_z  (sticky_z)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] out;
        logic       cout;
        logic       z;
    } vec_t;
    typedef struct {
        logic [IDW-1:0] id;
        logic [7:0]     out;
        logic           cout;
        logic           z;
    } rsp_t;
    rsp_t sb[$];
    rsp_t m_e;
    int   checks = 0;
    int   errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask
    function automatic rsp_t model(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        rsp_t r;
        int   x;
        int   y;
        x      = int'(a);
        y      = int'(b);
        r.id   = IDW'(id);
        r.cout = 1'b0;
        case (op)
            3'd0: begin r.out = 8'((x + y) % 256); r.cout = (x + y) > 255; end
            3'd1: begin r.out = 8'((x - y + 256) % 256); r.cout = x >= y; end
            3'd2: r.out = a & b;
            3'd3: r.out = a | b;
            3'd4: r.out = a ^ b;
            3'd5: r.out = (x > y) ? 8'd1 : 8'd0;
            3'd6: r.out = 8'((x * 2) % 256);
            default: r.out = 8'((y * 2) % 256);
        endcase
        r.z = r.out == 8'd0;
        return r;
    endfunction
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual id %0d required no response", rsp_id);
            end else begin
                m_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
                chk("rsp_out", 32'(rsp_out), 32'(m_e.out));
                chk("rsp_cout", 32'(rsp_cout), 32'(m_e.cout));
                chk("rsp_z", 32'(rsp_z), 32'(m_e.z));
            end
        end
    end
    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        req_a[id*8 +: 8]   = a;
        req_b[id*8 +: 8]   = b;
        req_op[id*3 +: 3]  = op;
    endtask
    task automatic wait_grant(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = |req_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual no grant required grant within 20 cycles", name);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    vec_t vecs[12];
    bit   ok;
    initial begin
        vecs[0]  = '{2, 8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{0, 8'h05, 8'h05, 3'd1, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{1, 8'h03, 8'h05, 3'd1, 8'hFE, 1'b0, 1'b0};
        vecs[3]  = '{3, 8'hCC, 8'hAA, 3'd2, 8'h88, 1'b0, 1'b0};
        vecs[4]  = '{0, 8'hCC, 8'hAA, 3'd3, 8'hEE, 1'b0, 1'b0};
        vecs[5]  = '{1, 8'hCC, 8'hCC, 3'd4, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{2, 8'h09, 8'h03, 3'd5, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{3, 8'h03, 8'h09, 3'd5, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{0, 8'h81, 8'h00, 3'd6, 8'h02, 1'b0, 1'b0};
        vecs[9]  = '{1, 8'h00, 8'hC0, 3'd7, 8'h80, 1'b0, 1'b0};
        vecs[10] = '{2, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{3, 8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_out", 32'(rsp_out), 0);
        chk("reset_rsp_cout", 32'(rsp_cout), 0);
        chk("reset_rsp_z", 32'(rsp_z), 0);
`ifdef ALU_RR_SCHED_STICKY_EN
        chk("reset_sticky_c", 32'(sticky_c), 0);
        chk("reset_sticky_z", 32'(sticky_z), 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            wait_grant("vec_grant", ok);
            if (ok) begin
                chk("vec_grant_onehot", 32'(req_ready), 32'(1) << vecs[i].id);
                sb.push_back('{IDW'(vecs[i].id), vecs[i].out, vecs[i].cout, vecs[i].z});
                step();
                req_valid = '0;
                chk("vec_exec_no_rsp", 32'(rsp_valid), 0);
                step();
                chk("vec_latency_valid", 32'(rsp_valid), 1);
                step();
                chk("vec_rsp_taken", 32'(rsp_valid), 0);
            end
        end
        rsp_ready = 1'b0;
        set_req(1, 8'h09, 8'h03, 3'd5);
        wait_grant("bp_grant", ok);
        if (ok) begin
            chk("bp_grant_onehot", 32'(req_ready), 32'h2);
            sb.push_back(model(1, 8'h09, 8'h03, 3'd5));
            step();
            req_valid = 4'b1101;
            step();
            for (int c = 0; c < 10; c++) begin
                chk("bp_valid_held", 32'(rsp_valid), 1);
                chk("bp_out_held", 32'(rsp_out), 32'h01);
                chk("bp_id_held", 32'(rsp_id), 1);
                chk("bp_no_grant", 32'(req_ready), 0);
                step();
            end
            req_valid = '0;
            rsp_ready = 1'b1;
            step();
            chk("bp_delivered", 32'(rsp_valid), 0);
        end
        set_req(2, 8'h11, 8'h22, 3'd0);
        wait_grant("rst_grant", ok);
        if (ok) begin
            sb.push_back(model(2, 8'h11, 8'h22, 3'd0));
            step();
            req_valid = '0;
            rst = 1'b1;
            #1;
            chk("midrst_rsp_valid", 32'(rsp_valid), 0);
            chk("midrst_state_idle", 32'(dut.state_q), 32'(IDLE));
            step();
            rst = 1'b0;
        end
        for (int r = 0; r < NREQ; r++) begin
            req_a[r*8 +: 8]  = 8'(8'h10 * r + 3);
            req_b[r*8 +: 8]  = 8'(8'h07 + r);
            req_op[r*3 +: 3] = 3'(r);
        end
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            wait_grant("fair_grant", ok);
            if (ok) begin
                chk("fair_onehot", 32'(req_ready), 32'(1) << (k % NREQ));
                sb.push_back(model(k % NREQ, 8'(8'h10 * (k % NREQ) + 3), 8'(8'h07 + k % NREQ), 3'(k % NREQ)));
                step();
            end
        end
        req_valid = '0;
`ifdef ALU_RR_SCHED_STICKY_EN
        repeat (3) step();
        set_req(0, 8'hFF, 8'h01, 3'd0);
        wait_grant("sticky_grant", ok);
        if (ok) begin
            sb.push_back(model(0, 8'hFF, 8'h01, 3'd0));
            step();
            req_valid = '0;
            step();
            chk("sticky_c_set", 32'(sticky_c), 1);
            chk("sticky_z_set", 32'(sticky_z), 1);
            sticky_clr = 1'b1;
            step();
            sticky_clr = 1'b0;
            chk("sticky_c_clr", 32'(sticky_c), 0);
            chk("sticky_z_clr", 32'(sticky_z), 0);
        end
`endif
        for (int c = 0; c < 50 && sb.size() != 0; c++) step();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
